// File: rtl/des_sbox_serial.sv
// Serial DES S-box substitution: one S-box lookup per clock, S1 first,
// with a start/busy/done handshake. The 48-bit input is latched on start.
module des_sbox_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iSb,
    input  logic [47:0] xin,
    output logic        busy,
    output logic        done,
    output logic [0:31] sOut
);

    localparam int unsigned XIN_W = 48;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned GRP_W = 6;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned TAB_W = 256;

    // Each table is 64 nibbles in reading order (row 0 col 0 in the top nibble).
    localparam logic [TAB_W-1:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [TAB_W-1:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [TAB_W-1:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [TAB_W-1:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [TAB_W-1:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [TAB_W-1:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [TAB_W-1:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [TAB_W-1:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SUB  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [XIN_W-1:0]   r_lat;
    logic [XIN_W-1:0]   w_lat_nxt;
    logic [OUT_W-1:0]   r_acc;
    logic [OUT_W-1:0]   w_acc_nxt;
    logic [OUT_W-1:0]   r_sout;
    logic [OUT_W-1:0]   w_sout_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic [5:0]         w_base;
    logic [GRP_W-1:0]   w_grp;
    logic [GRP_W-1:0]   w_addr;
    logic [TAB_W-1:0]   w_tab;
    logic [NIB_W-1:0]   w_nib;

    // State and datapath registers; reset discards any in-flight substitution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_lat   <= '0;
            r_acc   <= '0;
            r_sout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_lat   <= w_lat_nxt;
            r_acc   <= w_acc_nxt;
            r_sout  <= w_sout_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Shared 6-to-4 lookup for the group selected by r_idx (S1 = top six bits).
    always_comb begin
        w_base = 6'd42 - (6'(r_idx) * 6'd6);
        w_grp  = r_lat[w_base +: GRP_W];
        w_addr = {w_grp[5], w_grp[0], w_grp[4:1]};
        case (r_idx)
            3'd0:    w_tab = S1;
            3'd1:    w_tab = S2;
            3'd2:    w_tab = S3;
            3'd3:    w_tab = S4;
            3'd4:    w_tab = S5;
            3'd5:    w_tab = S6;
            3'd6:    w_tab = S7;
            default: w_tab = S8;
        endcase
        w_nib = w_tab[{6'd63 - w_addr, 2'b00} +: NIB_W];
    end

    // Next-state: start only from idle, finish after the eighth group.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (iSb) w_state_nxt = ST_SUB;
            ST_SUB:  if (r_idx == 3'd7) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values: accumulate nibbles, publish on the last one.
    always_comb begin
        w_idx_nxt  = r_idx;
        w_lat_nxt  = r_lat;
        w_acc_nxt  = r_acc;
        w_sout_nxt = r_sout;
        w_busy_nxt = r_busy;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iSb) begin
                    w_lat_nxt  = xin;
                    w_idx_nxt  = '0;
                    w_acc_nxt  = '0;
                    w_busy_nxt = 1'b1;
                end
            end
            ST_SUB: begin
                w_acc_nxt[{~r_idx, 2'b00} +: NIB_W] = w_nib;
                w_idx_nxt = IDX_W'(r_idx + 3'd1);
                if (r_idx == 3'd7) begin
                    w_sout_nxt = w_acc_nxt;
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                    w_idx_nxt  = '0;
                end
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sOut = r_sout;

endmodule

// File: tb/tb_des_sbox_serial.sv
// Self-checking bench for des_sbox_serial: cycle-level behavioural model
// built on FIPS 46-3 S-box tables, directed vectors and random stimulus.
module tb_des_sbox_serial;

    logic        clk;
    logic        rst_n;
    logic        iSb;
    logic [47:0] xin;
    logic        busy;
    logic        done;
    logic [0:31] sOut;

    int n_pass;
    int n_total;
    bit chk_en;

    des_sbox_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iSb   (iSb),
        .xin   (xin),
        .busy  (busy),
        .done  (done),
        .sOut  (sOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIPS 46-3 S-boxes, [box][row][col]
    int tbl [0:7][0:3][0:15] = '{
        '{ '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7},
           '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
           '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0},
           '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13} },
        '{ '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10},
           '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
           '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15},
           '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9} },
        '{ '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8},
           '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
           '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7},
           '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12} },
        '{ '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15},
           '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
           '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4},
           '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14} },
        '{ '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9},
           '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
           '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14},
           '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3} },
        '{ '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11},
           '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
           '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6},
           '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13} },
        '{ '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1},
           '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
           '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2},
           '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12} },
        '{ '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7},
           '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
           '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8},
           '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11} }
    };

    // Whole-word substitution from the tables with plain arithmetic
    function automatic logic [31:0] model_sbox(input logic [47:0] x);
        longint unsigned v;
        int six, row, col;
        logic [31:0] r;
        v = longint'(x);
        r = '0;
        for (int g = 0; g < 8; g++) begin
            six = int'((v >> (42 - 6 * g)) & 64'd63);
            row = ((six >> 5) & 1) * 2 + (six & 1);
            col = (six >> 1) & 15;
            r = (r << 4) | 32'(tbl[g][row][col]);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: edges elapsed since the last accepted start decide busy/done
    bit          m_valid;
    int          m_age;
    logic [47:0] m_x;
    logic [31:0] m_sout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_age   <= 0;
            m_x     <= '0;
            m_sout  <= '0;
        end else if (iSb && !(m_valid && m_age <= 7)) begin
            m_valid <= 1'b1;
            m_age   <= 0;
            m_x     <= xin;
        end else if (m_valid) begin
            if (m_age < 1000) m_age <= m_age + 1;
            if (m_age == 7) m_sout <= model_sbox(m_x);
        end
    end

    // Compare DUT outputs with the model every cycle, away from the rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 48'(busy), 48'(m_valid && m_age <= 7));
            chk("done", 48'(done), 48'(m_valid && m_age == 8));
            chk("sOut", 48'(sOut), 48'(m_sout));
        end
    end

    task automatic run_vec(input string nm, input logic [47:0] x, input logic [31:0] exp);
        int  k;
        int  bcnt;
        bit  got;
        logic [31:0] res;
        @(negedge clk);
        xin = x;
        iSb = 1'b1;
        k = 0; bcnt = 0; got = 1'b0; res = '0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                iSb = 1'b0;
                xin = {16'($urandom), $urandom};
            end
            if (busy) bcnt++;
            if (done) begin
                got = 1'b1;
                res = sOut;
            end
        end
        chk({nm, "_latency"}, 48'(got ? k - 1 : 999), 48'd8);
        chk({nm, "_busy_cycles"}, 48'(bcnt), 48'd8);
        chk({nm, "_result"}, 48'(res), 48'(exp));
    endtask

    initial begin
        int last;
        int cnt;
        n_pass = 0; n_total = 0; chk_en = 1'b0;
        iSb = 1'b0; xin = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;

        // Pin the model itself with hand-derived vectors
        chk("model_zero",  48'(model_sbox(48'h000000000000)), 48'hEFA72C4D);
        chk("model_ones",  48'(model_sbox(48'hFFFFFFFFFFFF)), 48'hD9CE3DCB);
        chk("model_fips",  48'(model_sbox(48'h6117BA866527)), 48'h5C82B597);
        chk("model_s1r1",  48'(model_sbox(48'h040000000000)), 48'h0FA72C4D);
        chk("model_s8r1",  48'(model_sbox(48'h000000000001)), 48'hEFA72C41);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_busy", 48'(busy), 48'd0);
        chk("idle_done", 48'(done), 48'd0);
        chk("idle_sOut", 48'(sOut), 48'h0);

        run_vec("zero", 48'h000000000000, 32'hEFA72C4D);
        run_vec("ones", 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
        run_vec("fips", 48'h6117BA866527, 32'h5C82B597);
        run_vec("s1_row1", 48'h040000000000, 32'h0FA72C4D);
        run_vec("s8_row1", 48'h000000000001, 32'hEFA72C41);

        // iSb held high: one result every 9 clocks
        @(negedge clk);
        xin = '0;
        iSb = 1'b1;
        last = -1; cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) chk("held_spacing", 48'(i - last), 48'd9);
                chk("held_sOut", 48'(sOut), 48'hEFA72C4D);
                cnt++;
                last = i;
            end
        end
        iSb = 1'b0;
        chk("held_pulses", 48'(cnt), 48'd3);
        repeat (10) @(negedge clk);

        // Reset mid-substitution discards the operation
        xin = 48'hFFFFFFFFFFFF;
        iSb = 1'b1;
        @(negedge clk);
        iSb = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_done", 48'(done), 48'd0);
        chk("rst_sOut", 48'(sOut), 48'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("rst_no_done", 48'(cnt), 48'd0);
        run_vec("fips_after_rst", 48'h6117BA866527, 32'h5C82B597);

        // Random starts and data, checked every cycle against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            iSb = ($urandom_range(0, 3) == 0);
            xin = {16'($urandom), $urandom};
        end
        iSb = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/des_sbox_serial.md
# des_sbox_serial

Serial DES S-box substitution unit: compresses the 48-bit round value (expansion output XOR round key) back to 32 bits through S-boxes S1..S8, one S-box per clock. It sits in the DES round datapath directly after the expansion stage and key XOR, and feeds the P permutation. It trades 8 cycles of latency for a single shared 6-to-4 lookup path, and uses a start/busy/done handshake.

## Interface
- Parameters: none.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- iSb  input  1  start strobe; sampled only when idle.
- xin  input  48 [47:0]  expanded-and-keyed value; bit 47 = DES bit 1.
- busy  output  1  high while a substitution is in progress.
- done  output  1  one-cycle pulse when sOut holds a new result.
- sOut  output  32 [0:31]  substitution result; index 0 = DES bit 1.

## Operation
- States:
  - IDLE: no substitution in progress.
  - SUB: substitution in progress; 3-bit group counter idx = 0..7.
- IDLE, iSb=1:
  - Latch xin into a 48-bit internal register.
  - Set idx=0, busy=1, go to SUB.
- IDLE, iSb=0: hold.
- SUB, each clock:
  - Take group g = idx+1, bits [47-6*idx -: 6] of the latched value.
  - Label the 6 bits b1..b6, with b1 the highest bit.
  - row = {b1,b6}; col = {b2,b3,b4,b5}.
  - Look up Sg[row][col] in the FIPS 46-3 tables, stored as constants.
  - Write the 4-bit result into accumulator nibble idx, MSB first: S1 goes to sOut[0:3], S8 to sOut[28:31].
- SUB, idx=7:
  - Load the full accumulator, including the nibble computed this cycle, into sOut.
  - Pulse done=1, clear busy, return to IDLE.
- sOut changes only at completion. It holds the previous result throughout SUB.
- iSb while busy: ignored, with no queuing.
- xin changing after the start edge: no effect on the result.
- Reset (asynchronous, any state, including mid-SUB):
  - Go to IDLE, idx=0.
  - busy=0, done=0, sOut=32'h0, accumulator and latch cleared.
  - An in-flight operation is discarded with no done pulse.

## Timing
- All outputs are registered.
- Start edge E0: iSb=1 in IDLE. busy is high from E0.
- Edges E1..E8 process S1..S8.
- At E8: sOut is updated, done rises, busy falls.
- done is high exactly one cycle (E8 to E9).
- Latency: 8 clocks from the start edge to sOut valid.
- Back-to-back: iSb may be asserted in the done cycle (state is IDLE) and is accepted at E9. Minimum start-to-start spacing is 9 clocks. Holding iSb=1 continuously gives one result every 9 clocks.
- iSb high during the E8 cycle (still SUB): ignored.

## Test plan
- Reset, then idle: after reset release, busy=0, done=0, sOut=32'h00000000 for 20 cycles with iSb=0.
- Zero vector: xin=48'h000000000000, iSb pulse -> done exactly 8 clocks after the start edge, sOut=32'hEFA72C4D, busy high for exactly 8 cycles.
- All-ones: xin=48'hFFFFFFFFFFFF -> sOut=32'hD9CE3DCB.
- FIPS round-1 vector: xin=48'h6117BA866527 -> sOut=32'h5C82B597.
- Row/column decode and group order:
  - xin=48'h040000000000 (S1 input 000001, row 1 col 0) -> sOut=32'h0FA72C4D.
  - xin=48'h000000000001 (S8 input 000001, row 1 col 0) -> sOut=32'hEFA72C41.
- Handshake and reset:
  - iSb held high for 30 cycles with the zero vector -> done pulses spaced exactly 9 clocks apart, each with sOut=32'hEFA72C4D.
  - Start the all-ones vector, then drop rst_n at E4 -> busy, done and sOut go to 0 immediately and no done pulse follows.
  - Restart the FIPS vector -> 32'h5C82B597.
